// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus between the fetch/PC stage and instruction memory.
// The fetch unit is the master; memory answers with ready/rdata.
interface fetch_pc_unit_if #(
    parameter int AW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [15:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage: fetches 16-bit words, holds them for
// decode and computes the next PC from the control unit's PCsrc on retire.
//
//   state  | meaning
//   IDLE   | out of reset, one cycle before the first fetch
//   FETCH  | imem_req high at PC, waiting for imem_ready
//   VALID  | instruction held for decode, waiting for exec_ready (retire)
//   HALTED | halt retired; PC frozen at its next value until reset
module fetch_pc_unit #(
    parameter int              AW             = 16,
    parameter logic [AW-1:0]   RESET_PC       = '0,
    parameter logic [15:0]     RETIRE_CNT_RST = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_pc_unit_if.master     imem,
    output logic [15:0]         instr_o,
    output logic [3:0]          op_o,
    output logic                instr_valid_o,
    output logic [AW-1:0]       pc_out_o,
    output logic [AW-1:0]       pc_plus2_o,
    input  logic                exec_ready_i,
    input  logic [1:0]          pcsrc_i,
    input  logic [AW-1:0]       imm_i,
    input  logic [AW-1:0]       rs1_val_i,
    input  logic                halt_i,
    output logic                misalign_err_o,
    output logic                pcsrc_err_o,
    output logic [15:0]         retire_cnt_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_VALID  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [AW-1:0] PC_INC = AW'(2);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   instr_q, instr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          misalign_q, misalign_d;
    logic          pcsrc_err_q, pcsrc_err_d;
    logic [AW-1:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            cnt_q       <= RETIRE_CNT_RST;
            misalign_q  <= 1'b0;
            pcsrc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            misalign_q  <= misalign_d;
            pcsrc_err_q <= pcsrc_err_d;
        end
    end

    // Reserved PCsrc encoding falls back to sequential flow.
    always_comb begin
        target = pc_q + PC_INC;
        case (pcsrc_i)
            2'd1:    target = pc_q + imm_i;
            2'd2:    target = rs1_val_i + imm_i;
            default: target = pc_q + PC_INC;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        misalign_d  = misalign_q;
        pcsrc_err_d = pcsrc_err_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (exec_ready_i) begin
                    // Odd targets are flagged and forced back to halfword alignment.
                    pc_d  = {target[AW-1:1], 1'b0};
                    cnt_d = cnt_q + 16'd1;
                    if (target[0])
                        misalign_d = 1'b1;
                    if (pcsrc_i == 2'd3)
                        pcsrc_err_d = 1'b1;
                    state_d = halt_i ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid_o  = (state_q == S_VALID);
    assign instr_o        = instr_q;
    assign op_o           = instr_q[15:12];
    assign pc_out_o       = pc_q;
    assign pc_plus2_o     = pc_q + PC_INC;
    assign misalign_err_o = misalign_q;
    assign pcsrc_err_o    = pcsrc_err_q;
    assign retire_cnt_o   = cnt_q;
endmodule
